mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//   Memory-access stage: consumes execute-stage requests (rw/addr/data) and runs them on the data bus.
//   Drives the req/gnt/rvalid data bus as initiator, with byte lanes and load extension.
//   Registers the GPR writeback toward WB and holds the pipeline via stall_o while a transaction is open.
//   Sits between the EX_MEM pipeline register and the writeback/regfile.
// PARAMETERS
//   TIMEOUT  256  max cycles in REQ+WAIT before the transaction aborts with err_o (>=2)
// PORTS
//   clk           in   1   clock, rising edge
//   rst_n         in   1   reset, asynchronous, active-low
//   mem_req_i     in   1   EX presents a load/store this cycle
//   mem_rw_i      in   1   `MEM_READ (0) load / `MEM_WRITE (1) store
//   mem_size_i    in   2   00 byte, 01 half, 10 word (11 treated as word)
//   mem_sext_i    in   1   load: 1 sign-extend, 0 zero-extend
//   mem_addr_i    in   32  byte address
//   mem_data_i    in   32  store data, low bits significant
//   gprs_waddr_i  in   5   destination register (load or ALU result)
//   gprs_wdata_i  in   32  ALU result, used when mem_req_i=0
//   dbus_req_o    out  1   bus request, held until dbus_gnt_i
//   dbus_we_o     out  1   1 write, 0 read
//   dbus_addr_o   out  32  word-aligned address ({addr[31:2],2'b00})
//   dbus_be_o     out  4   byte enables
//   dbus_wdata_o  out  32  lane-replicated store data
//   dbus_gnt_i    in   1   request accepted this cycle
//   dbus_rvalid_i in   1   response/completion (loads and stores)
//   dbus_rdata_i  in   32  read data, valid with rvalid
//   gprs_waddr_o  out  5   registered writeback address (`REG_X0 = no write)
//   gprs_wdata_o  out  32  registered writeback data
//   stall_o       out  1   combinational; freezes IF/ID/EX
//   err_o         out  1   one-cycle pulse: misaligned access or bus timeout
// BEHAVIOUR
//   Reset: state IDLE; dbus_req_o=0, dbus_we_o=0, dbus_addr_o=0, dbus_be_o=0, dbus_wdata_o=0.
//     gprs_waddr_o=`REG_X0, gprs_wdata_o=0, err_o=0, timeout counter=0.
//   FSM states: IDLE, REQ, WAIT.
//   IDLE, mem_req_i=0: gprs_waddr_o<=gprs_waddr_i, gprs_wdata_o<=gprs_wdata_i (1-cycle passthrough).
//   IDLE, mem_req_i=1, aligned: latch the request and drive the bus registers; dbus_req_o=1 next cycle.
//     State -> REQ; writeback regs <= `REG_X0.
//   IDLE, misaligned (half with addr[0]=1, word with addr[1:0]!=0): no bus activity.
//     err_o pulses next cycle; gprs_waddr_o<=`REG_X0; stays IDLE.
//   REQ: hold all bus outputs stable until dbus_gnt_i; then drop dbus_req_o.
//     Same-cycle gnt+rvalid completes directly from REQ; otherwise state -> WAIT.
//   WAIT: on dbus_rvalid_i -> IDLE.
//     Load: gprs_waddr_o<=latched waddr, gprs_wdata_o<=extended data. Store: gprs_waddr_o<=`REG_X0.
//   Byte lanes, o = addr[1:0]:
//     SB: be=4'b0001<<o, wdata={4{data[7:0]}}.
//     SH: be=addr[1]?1100:0011, wdata={2{data[15:0]}}.
//     SW: be=1111, wdata=data.
//   Load data: sh=rdata>>(8*o); byte/half then sign- or zero-extended to 32 bits per mem_sext_i.
//   stall_o = (state!=IDLE) | (state==IDLE & mem_req_i & aligned).
//     Low on the completion cycle's next edge, so EX advances exactly once per access.
//   Timeout: counter clears on leaving IDLE and increments each cycle in REQ/WAIT.
//     At count==TIMEOUT-1 without completion: dbus_req_o<=0, err_o pulse, waddr_o=`REG_X0, -> IDLE.
//   In IDLE, dbus_rvalid_i/dbus_gnt_i are ignored (covers stale responses after reset or timeout).
//   Reset asserted mid-transaction: immediate return to reset values; the in-flight access is discarded.
//   Latency, load with gnt on first REQ cycle and rvalid one cycle later:
//     sample at T0; req at T1; rvalid at T2; gprs_waddr_o valid T3; stall_o high T0..T2.
// TESTING
//   1 LW addr=0x100, gnt T1, rvalid T2, rdata=0xDEADBEEF, waddr=5
//     -> be=1111, addr 0x100; T3 waddr_o=5, wdata_o=0xDEADBEEF; stall T0-T2.
//   2 LB sext addr=0x103, rdata=0x80FF0000 -> wdata_o=0xFFFFFF80.
//     Same with LBU -> 0x00000080; LHU addr=0x102 -> 0x000080FF.
//   3 SH addr=0x202, data=0x1234ABCD -> be=1100, wdata=0xABCDABCD, we=1; completion gives waddr_o=x0.
//   4 Gnt withheld 5 cycles -> req/addr/be/wdata stable throughout.
//     Gnt+rvalid same cycle -> completes with no WAIT cycle.
//   5 LW addr=0x101 -> no dbus_req_o, err_o 1 cycle, stall_o never high.
//     TIMEOUT=8 with no gnt -> err_o at cycle 8, req dropped, IDLE.
//   6 rst_n low during WAIT -> all outputs reset asynchronously.
//     A later rvalid is ignored; passthrough ALU write (waddr=3, wdata=7) appears one cycle after sampling.

Source files
------------

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_if
//  Description : Data-bus bundle between the memory stage (initiator) and
//                the data memory / interconnect (target). Carries the
//                req/gnt/rvalid handshake, byte lanes and data.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Memory-access pipeline stage. Turns EX load/store requests
//                into req/gnt/rvalid bus transactions with byte lanes, extends
//                load data, registers the GPR writeback and stalls the front
//                of the pipe while an access is open. Aborts on misalignment
//                or bus timeout with a one-cycle err_o pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int TIMEOUT = 256
) (
    input  wire         clk,
    input  wire         rst_n,
    input  wire         mem_req_i,
    input  wire         mem_rw_i,
    input  wire  [1:0]  mem_size_i,
    input  wire         mem_sext_i,
    input  wire  [31:0] mem_addr_i,
    input  wire  [31:0] mem_data_i,
    input  wire  [4:0]  gprs_waddr_i,
    input  wire  [31:0] gprs_wdata_i,
    mem_stage_if.master dbus,
    output logic [4:0]  gprs_waddr_o,
    output logic [31:0] gprs_wdata_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam logic [4:0] REG_X0 = 5'd0;
    localparam int         CNT_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [1:0]         size_q, size_d;
    logic               sext_q, sext_d;
    logic [1:0]         off_q, off_d;
    logic [4:0]         dst_q, dst_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         gwaddr_q, gwaddr_d;
    logic [31:0]        gwdata_q, gwdata_d;
    logic               err_q, err_d;

    logic               w_aligned;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_shift;
    logic [31:0]        w_ldata;
    logic               w_tmo;
    logic               w_done;

    // Alignment check and lane steering for the request presented by EX.
    always_comb begin
        w_aligned = 1'b1;
        w_be      = 4'b1111;
        w_wdata   = mem_data_i;
        case (mem_size_i)
            2'b00: begin
                w_be    = 4'b0001 << mem_addr_i[1:0];
                w_wdata = {4{mem_data_i[7:0]}};
            end
            2'b01: begin
                w_aligned = ~mem_addr_i[0];
                w_be      = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{mem_data_i[15:0]}};
            end
            default: begin
                w_aligned = (mem_addr_i[1:0] == 2'b00);
            end
        endcase
    end

    // Move the addressed lane down to bit 0 and extend it to 32 bits.
    always_comb begin
        w_shift = dbus.rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   w_ldata = sext_q ? {{24{w_shift[7]}}, w_shift[7:0]}
                                      : {24'd0, w_shift[7:0]};
            2'b01:   w_ldata = sext_q ? {{16{w_shift[15]}}, w_shift[15:0]}
                                      : {16'd0, w_shift[15:0]};
            default: w_ldata = w_shift;
        endcase
    end

    assign w_tmo   = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign stall_o = (state_q != S_IDLE) | (mem_req_i & w_aligned);

    // Next-state logic: accept, hold, complete or abort the bus access.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        sext_d   = sext_q;
        off_d    = off_q;
        dst_d    = dst_q;
        cnt_d    = cnt_q;
        gwaddr_d = gwaddr_q;
        gwdata_d = gwdata_q;
        err_d    = 1'b0;
        w_done   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!mem_req_i) begin
                    gwaddr_d = gprs_waddr_i;
                    gwdata_d = gprs_wdata_i;
                end else if (w_aligned) begin
                    state_d  = S_REQ;
                    req_d    = 1'b1;
                    we_d     = mem_rw_i;
                    addr_d   = {mem_addr_i[31:2], 2'b00};
                    be_d     = w_be;
                    wdata_d  = w_wdata;
                    size_d   = mem_size_i;
                    sext_d   = mem_sext_i;
                    off_d    = mem_addr_i[1:0];
                    dst_d    = gprs_waddr_i;
                    cnt_d    = '0;
                    gwaddr_d = REG_X0;
                    gwdata_d = 32'd0;
                end else begin
                    err_d    = 1'b1;
                    gwaddr_d = REG_X0;
                    gwdata_d = 32'd0;
                end
            end
            S_REQ: begin
                w_done = dbus.gnt & dbus.rvalid;
                if (dbus.gnt && !dbus.rvalid) begin
                    req_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                w_done = dbus.rvalid;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase

        // Completion wins over timeout when both land on the same cycle.
        if (state_q == S_REQ || state_q == S_WAIT) begin
            if (w_done) begin
                state_d  = S_IDLE;
                req_d    = 1'b0;
                gwaddr_d = we_q ? REG_X0 : dst_q;
                gwdata_d = we_q ? 32'd0 : w_ldata;
            end else if (w_tmo) begin
                state_d  = S_IDLE;
                req_d    = 1'b0;
                err_d    = 1'b1;
                gwaddr_d = REG_X0;
                gwdata_d = 32'd0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State and output registers; reset discards any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            size_q   <= 2'd0;
            sext_q   <= 1'b0;
            off_q    <= 2'd0;
            dst_q    <= REG_X0;
            cnt_q    <= '0;
            gwaddr_q <= REG_X0;
            gwdata_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            sext_q   <= sext_d;
            off_q    <= off_d;
            dst_q    <= dst_d;
            cnt_q    <= cnt_d;
            gwaddr_q <= gwaddr_d;
            gwdata_q <= gwdata_d;
            err_q    <= err_d;
        end
    end

    assign dbus.req     = req_q;
    assign dbus.we      = we_q;
    assign dbus.addr    = addr_q;
    assign dbus.be      = be_q;
    assign dbus.wdata   = wdata_q;
    assign gprs_waddr_o = gwaddr_q;
    assign gprs_wdata_o = gwdata_q;
    assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage: directed accesses,
//                misalignment, timeout, mid-access reset, then randomized
//                aligned loads/stores against a lane/extension model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req_i = 1'b0;
    logic        mem_rw_i = 1'b0;
    logic [1:0]  mem_size_i = 2'b00;
    logic        mem_sext_i = 1'b0;
    logic [31:0] mem_addr_i = 32'd0;
    logic [31:0] mem_data_i = 32'd0;
    logic [4:0]  gprs_waddr_i = 5'd0;
    logic [31:0] gprs_wdata_i = 32'd0;
    logic [4:0]  gprs_waddr_o;
    logic [31:0] gprs_wdata_o;
    logic        stall_o;
    logic        err_o;

    int nchk = 0;
    int nfail = 0;

    mem_stage_if dbus_if ();

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_req_i    (mem_req_i),
        .mem_rw_i     (mem_rw_i),
        .mem_size_i   (mem_size_i),
        .mem_sext_i   (mem_sext_i),
        .mem_addr_i   (mem_addr_i),
        .mem_data_i   (mem_data_i),
        .gprs_waddr_i (gprs_waddr_i),
        .gprs_wdata_i (gprs_wdata_i),
        .dbus         (dbus_if),
        .gprs_waddr_o (gprs_waddr_o),
        .gprs_wdata_o (gprs_wdata_o),
        .stall_o      (stall_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model, written from the lane/extension rules.
    function automatic logic [31:0] m_be(input logic [1:0] sz, input logic [1:0] o);
        int unsigned v;
        if (sz == 2'd0)      v = 1 << o;
        else if (sz == 2'd1) v = (o >= 2) ? 12 : 3;
        else                 v = 15;
        return v;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0)      return (d % 256) * 32'h0101_0101;
        else if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
        else                 return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sx,
                                           input logic [1:0] o, input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] v;
        sh = rd / (32'd1 << (8 * o));
        if (sz == 2'd0) begin
            v = sh % 256;
            if (sx && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = sh % 65536;
            if (sx && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = sh;
        end
        return v;
    endfunction

    // One aligned access; gnt after gdelay held cycles, rvalid with gnt or one cycle later.
    task automatic do_access(input string tag, input logic rw, input logic [1:0] sz,
                             input logic sx, input logic [31:0] addr, input logic [31:0] data,
                             input logic [4:0] wa, input logic [31:0] rd,
                             input int gdelay, input logic same);
        @(posedge clk); #1;
        mem_req_i = 1'b1; mem_rw_i = rw; mem_size_i = sz; mem_sext_i = sx;
        mem_addr_i = addr; mem_data_i = data; gprs_waddr_i = wa; gprs_wdata_i = $urandom;
        #1 check({tag, ".stall_T0"}, 32'(stall_o), 32'd1);
        @(posedge clk); #1;
        mem_req_i = 1'b0; gprs_waddr_i = 5'd31;
        for (int i = 0; i <= gdelay; i++) begin
            #1;
            check({tag, ".req"}, 32'(dbus_if.req), 32'd1);
            check({tag, ".we"}, 32'(dbus_if.we), 32'(rw));
            check({tag, ".addr"}, dbus_if.addr, addr & 32'hFFFF_FFFC);
            check({tag, ".be"}, 32'(dbus_if.be), m_be(sz, addr[1:0]));
            if (rw) check({tag, ".wdata"}, dbus_if.wdata, m_wdata(sz, data));
            check({tag, ".stall"}, 32'(stall_o), 32'd1);
            dbus_if.rdata = $urandom;
            if (i == gdelay) begin
                dbus_if.gnt = 1'b1;
                if (same) begin
                    dbus_if.rvalid = 1'b1;
                    dbus_if.rdata  = rd;
                end
            end
            @(posedge clk); #1;
            dbus_if.gnt = 1'b0; dbus_if.rvalid = 1'b0;
        end
        if (!same) begin
            #1;
            check({tag, ".req_wait"}, 32'(dbus_if.req), 32'd0);
            check({tag, ".stall_wait"}, 32'(stall_o), 32'd1);
            dbus_if.rvalid = 1'b1; dbus_if.rdata = rd;
            @(posedge clk); #1;
            dbus_if.rvalid = 1'b0;
        end
        #1;
        check({tag, ".stall_done"}, 32'(stall_o), 32'd0);
        check({tag, ".err"}, 32'(err_o), 32'd0);
        check({tag, ".req_done"}, 32'(dbus_if.req), 32'd0);
        if (rw) begin
            check({tag, ".waddr_st"}, 32'(gprs_waddr_o), 32'd0);
        end else begin
            check({tag, ".waddr_ld"}, 32'(gprs_waddr_o), 32'(wa));
            check({tag, ".wdata_ld"}, gprs_wdata_o, m_load(sz, sx, addr[1:0], rd));
        end
    endtask

    initial begin
        logic [1:0]  sz;
        logic [1:0]  o;
        logic [31:0] a;
        dbus_if.gnt = 1'b0; dbus_if.rvalid = 1'b0; dbus_if.rdata = 32'd0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst.req", 32'(dbus_if.req), 32'd0);
        check("rst.addr", dbus_if.addr, 32'd0);
        check("rst.be", 32'(dbus_if.be), 32'd0);
        check("rst.waddr", 32'(gprs_waddr_o), 32'd0);
        check("rst.err", 32'(err_o), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Directed accesses
        do_access("lw",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, 1'b0);
        do_access("lb",  1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd6, 32'h80FF0000, 0, 1'b0);
        do_access("lbu", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd7, 32'h80FF0000, 0, 1'b0);
        do_access("lhu", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 5'd8, 32'h80FF0000, 0, 1'b0);
        do_access("sh",  1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 5'd9, 32'h0, 0, 1'b0);
        do_access("hold", 1'b1, 2'b00, 1'b0, 32'h301, 32'h000000A5, 5'd4, 32'h0, 5, 1'b0);
        do_access("same", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd10, 32'h12345678, 2, 1'b1);

        // Misaligned word: no bus activity, one-cycle error
        @(posedge clk); #1;
        mem_req_i = 1'b1; mem_rw_i = 1'b0; mem_size_i = 2'b10; mem_addr_i = 32'h101;
        gprs_waddr_i = 5'd12;
        #1 check("mis.stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        mem_req_i = 1'b0;
        #1;
        check("mis.err", 32'(err_o), 32'd1);
        check("mis.req", 32'(dbus_if.req), 32'd0);
        check("mis.waddr", 32'(gprs_waddr_o), 32'd0);
        check("mis.stall2", 32'(stall_o), 32'd0);
        @(posedge clk); #2;
        check("mis.err_pulse", 32'(err_o), 32'd0);

        // Timeout: no grant ever
        @(posedge clk); #1;
        mem_req_i = 1'b1; mem_rw_i = 1'b0; mem_size_i = 2'b10; mem_addr_i = 32'h500;
        @(posedge clk); #1;
        mem_req_i = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            #1;
            check("tmo.req_held", 32'(dbus_if.req), 32'd1);
            check("tmo.no_err", 32'(err_o), 32'd0);
            @(posedge clk); #1;
        end
        #1;
        check("tmo.err", 32'(err_o), 32'd1);
        check("tmo.req_drop", 32'(dbus_if.req), 32'd0);
        check("tmo.waddr", 32'(gprs_waddr_o), 32'd0);
        check("tmo.idle", 32'(stall_o), 32'd0);
        @(posedge clk); #2;
        check("tmo.err_pulse", 32'(err_o), 32'd0);

        // Reset during WAIT, then a stale rvalid and an ALU passthrough
        @(posedge clk); #1;
        mem_req_i = 1'b1; mem_rw_i = 1'b0; mem_size_i = 2'b10; mem_addr_i = 32'h600;
        gprs_waddr_i = 5'd20;
        @(posedge clk); #1;
        mem_req_i = 1'b0; dbus_if.gnt = 1'b1;
        @(posedge clk); #1;
        dbus_if.gnt = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst.req", 32'(dbus_if.req), 32'd0);
        check("arst.addr", dbus_if.addr, 32'd0);
        check("arst.be", 32'(dbus_if.be), 32'd0);
        check("arst.stall", 32'(stall_o), 32'd0);
        rst_n = 1'b1;
        dbus_if.rvalid = 1'b1; dbus_if.rdata = 32'hCAFEF00D;
        gprs_waddr_i = 5'd3; gprs_wdata_i = 32'd7;
        @(posedge clk); #1;
        dbus_if.rvalid = 1'b0;
        #1;
        check("stale.waddr", 32'(gprs_waddr_o), 32'd3);
        check("stale.wdata", gprs_wdata_o, 32'd7);
        check("stale.req", 32'(dbus_if.req), 32'd0);
        check("stale.err", 32'(err_o), 32'd0);

        // Randomized aligned accesses
        for (int n = 0; n < 40; n++) begin
            sz = 2'($urandom_range(0, 3));
            if (sz == 2'd0)      o = 2'($urandom_range(0, 3));
            else if (sz == 2'd1) o = 2'(2 * $urandom_range(0, 1));
            else                 o = 2'd0;
            a = ($urandom & 32'hFFFF_FFFC) | 32'(o);
            do_access("rnd", 1'($urandom), sz, 1'($urandom), a, $urandom,
                      5'($urandom_range(1, 31)), $urandom,
                      int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
`default_nettype wire
